// File: rtl/lzw_string_unwinder.sv
// lzw_string_unwinder: unwinds one LZW code into its byte string.
// Walks the prefix chain in the dictionary RAM, stacks each append byte,
// then streams the stacked bytes out root-first over valid/ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   code_valid/code_in/code_ready   upstream code handshake
//   dict_addr                  registered dictionary read address
//   prefix_data/append_data    dictionary read data (RD_LAT cycles after dict_addr)
//   char_out/char_valid/char_ready/char_last   downstream byte stream
//   first_char                 root byte of the latest decoded string
//   busy                       FSM not in IDLE
//   err_overflow               sticky stack overflow flag
module lzw_string_unwinder #(
  parameter int unsigned STACK_DEPTH = 4096,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        code_valid,
  input  logic [12:0] code_in,
  output logic        code_ready,
  output logic [12:0] dict_addr,
  input  logic [12:0] prefix_data,
  input  logic [7:0]  append_data,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        char_last,
  output logic [7:0]  first_char,
  output logic        busy,
  output logic        err_overflow
);

  localparam int unsigned CODE_W = 13;
  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CNT_W  = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned PTR_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned WAIT_W = 2;

  localparam logic [CODE_W-1:0] LIT_LIMIT = CODE_W'(256);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_DONE = WAIT_W'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    PUSH_ROOT = 2'd2,
    EMIT      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CHAR_W-1:0]   root_q, root_d;
  logic [CODE_W-1:0]   addr_d;
  logic [CHAR_W-1:0]   first_d;
  logic                ovf_d;
  logic [CHAR_W-1:0]   char_out_d;
  logic                char_valid_d;
  logic                char_last_d;
  logic                busy_d;
  logic                code_ready_d;

  logic                push;
  logic                push_ok;
  logic                pop;
  logic [CHAR_W-1:0]   push_data;
  logic [PTR_W-1:0]    push_ptr;
  logic [PTR_W-1:0]    next_top_ptr;

  logic [CHAR_W-1:0]   stack [STACK_DEPTH];

  // Write slot is the current count; after a pop the new top sits two below.
  assign push_ptr     = PTR_W'(cnt_q);
  assign next_top_ptr = PTR_W'(cnt_q - CNT_W'(2));

  // Next-state, stack control and next values of all registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    root_d    = root_q;
    addr_d    = dict_addr;
    first_d   = first_char;
    ovf_d     = err_overflow;
    push      = 1'b0;
    push_ok   = 1'b0;
    pop       = 1'b0;
    push_data = '0;

    unique case (state_q)
      IDLE: begin
        if (code_valid && code_ready) begin
          if (code_in < LIT_LIMIT) begin
            root_d  = code_in[CHAR_W-1:0];
            state_d = PUSH_ROOT;
          end else begin
            addr_d  = code_in;
            wait_d  = '0;
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (wait_q == WAIT_DONE) begin
          push      = 1'b1;
          push_data = append_data;
          if (prefix_data < LIT_LIMIT) begin
            root_d  = prefix_data[CHAR_W-1:0];
            state_d = PUSH_ROOT;
          end else begin
            addr_d = prefix_data;
            wait_d = '0;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      PUSH_ROOT: begin
        push      = 1'b1;
        push_data = root_q;
        first_d   = root_q;
        state_d   = EMIT;
      end
      EMIT: begin
        if (char_valid && char_ready) begin
          pop = 1'b1;
          if (cnt_q == CNT_ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A push into a full stack aborts the string; this also ends looping chains.
    if (push) begin
      if (cnt_q == CNT_FULL) begin
        ovf_d   = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        push_ok = 1'b1;
        cnt_d   = cnt_q + CNT_ONE;
      end
    end else if (pop) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    // char_out tracks the stack top so it is ready the cycle EMIT starts.
    if (push_ok)  char_out_d = push_data;
    else if (pop) char_out_d = stack[next_top_ptr];
    else          char_out_d = char_out;

    char_valid_d = (state_d == EMIT) && (cnt_d != '0);
    char_last_d  = char_valid_d && (cnt_d == CNT_ONE);
    busy_d       = (state_d != IDLE);
    // Ready returns one cycle after the FSM has settled back in IDLE.
    code_ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wait_q       <= '0;
      root_q       <= '0;
      dict_addr    <= '0;
      first_char   <= '0;
      err_overflow <= 1'b0;
      char_out     <= '0;
      char_valid   <= 1'b0;
      char_last    <= 1'b0;
      busy         <= 1'b0;
      code_ready   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      root_q       <= root_d;
      dict_addr    <= addr_d;
      first_char   <= first_d;
      err_overflow <= ovf_d;
      char_out     <= char_out_d;
      char_valid   <= char_valid_d;
      char_last    <= char_last_d;
      busy         <= busy_d;
      code_ready   <= code_ready_d;
    end
  end

  // LIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) stack[push_ptr] <= push_data;
  end

endmodule

// File: tb/tb_lzw_string_unwinder.sv
// Bench for lzw_string_unwinder: three instances (default, STACK_DEPTH=4,
// RD_LAT=3) share one dictionary model; a scoreboard queue holds expected
// {last, byte} pairs and a monitor pops them as bytes are accepted.
module tb_lzw_string_unwinder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        code_valid  [NI];
  logic [12:0] code_in     [NI];
  logic        code_ready  [NI];
  logic [12:0] dict_addr   [NI];
  logic [12:0] prefix_data [NI];
  logic [7:0]  append_data [NI];
  logic [7:0]  char_out    [NI];
  logic        char_valid  [NI];
  logic        char_ready  [NI];
  logic        char_last   [NI];
  logic [7:0]  first_char  [NI];
  logic        busy        [NI];
  logic        err_overflow[NI];

  logic [12:0] dict_pre [4096];
  logic [7:0]  dict_app [4096];

  logic [8:0]  exp_q[$];
  int          passed = 0;
  int          total  = 0;
  int          sel    = 0;
  int          rdy_mode = 0;
  int          cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 2) ? 3 : 1;
    logic [12:0] pq [L];
    logic [7:0]  aq [L];

    lzw_string_unwinder #(
      .STACK_DEPTH((g == 1) ? 4 : 4096),
      .RD_LAT     (L)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .code_valid  (code_valid[g]),
      .code_in     (code_in[g]),
      .code_ready  (code_ready[g]),
      .dict_addr   (dict_addr[g]),
      .prefix_data (prefix_data[g]),
      .append_data (append_data[g]),
      .char_out    (char_out[g]),
      .char_valid  (char_valid[g]),
      .char_ready  (char_ready[g]),
      .char_last   (char_last[g]),
      .first_char  (first_char[g]),
      .busy        (busy[g]),
      .err_overflow(err_overflow[g])
    );

    // Dictionary RAM model with an L-cycle read pipeline.
    always @(posedge clk) begin
      pq[0] <= dict_pre[dict_addr[g][11:0]];
      aq[0] <= dict_app[dict_addr[g][11:0]];
      for (int k = 1; k < L; k++) begin
        pq[k] <= pq[k-1];
        aq[k] <= aq[k-1];
      end
    end
    assign prefix_data[g] = pq[L-1];
    assign append_data[g] = aq[L-1];
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = never.
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) begin
      case (rdy_mode)
        1:       char_ready[i] = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       char_ready[i] = 1'b0;
        default: char_ready[i] = 1'b1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic push_exp(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  // Scoreboard monitor and hold-while-stalled check on the selected instance.
  initial begin
    logic [8:0] e;
    logic [8:0] held;
    bit         stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid_hold", 32'(char_valid[sel]), 32'd1);
          chk("stall_data_hold", 32'({char_last[sel], char_out[sel]}), 32'(held));
        end
        if (char_valid[sel] && char_ready[sel]) begin
          chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("char_last_out", 32'({char_last[sel], char_out[sel]}), 32'(e));
          end
        end
        stalled = char_valid[sel] && !char_ready[sel];
        held    = {char_last[sel], char_out[sel]};
      end
    end
  end

  task automatic check_reset(input int g, input string tag);
    chk({tag, "_busy"},       32'(busy[g]), 32'd0);
    chk({tag, "_code_ready"}, 32'(code_ready[g]), 32'd1);
    chk({tag, "_char_valid"}, 32'(char_valid[g]), 32'd0);
    chk({tag, "_char_last"},  32'(char_last[g]), 32'd0);
    chk({tag, "_dict_addr"},  32'(dict_addr[g]), 32'd0);
    chk({tag, "_first_char"}, 32'(first_char[g]), 32'd0);
    chk({tag, "_err_ovf"},    32'(err_overflow[g]), 32'd0);
  endtask

  // Issue one code; check first-valid and ready-return cycles relative to accept.
  task automatic run(input int g, input logic [12:0] c, input int exp_valid, input int exp_ready);
    int k;
    @(negedge clk);
    chk("code_ready_idle", 32'(code_ready[g]), 32'd1);
    code_valid[g] = 1'b1;
    code_in[g]    = c;
    @(negedge clk);
    code_valid[g] = 1'b0;
    k = 1;
    while (!char_valid[g] && k < 100) begin @(negedge clk); k++; end
    chk("first_valid_cycle", 32'(k), 32'(exp_valid));
    while (!code_ready[g] && k < 200) begin @(negedge clk); k++; end
    chk("code_ready_cycle", 32'(k), 32'(exp_ready));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int  k;
    bit  seen;
    for (int i = 0; i < 4096; i++) begin
      dict_pre[i] = '0;
      dict_app[i] = '0;
    end
    dict_pre[12'h100] = 13'h041; dict_app[12'h100] = 8'h42;
    dict_pre[12'h101] = 13'h100; dict_app[12'h101] = 8'h43;
    dict_pre[12'h200] = 13'h030; dict_app[12'h200] = 8'h61;
    dict_pre[12'h201] = 13'h200; dict_app[12'h201] = 8'h62;
    dict_pre[12'h202] = 13'h201; dict_app[12'h202] = 8'h63;
    dict_pre[12'h203] = 13'h202; dict_app[12'h203] = 8'h64;
    dict_pre[12'h204] = 13'h203; dict_app[12'h204] = 8'h65;
    for (int i = 0; i < NI; i++) begin
      code_valid[i] = 1'b0;
      code_in[i]    = '0;
      char_ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(0, "por");
    rst_n = 1'b1;

    // Literal 0x041.
    sel = 0;
    push_exp(8'h41, 1'b1);
    run(0, 13'h041, 2, 4);
    chk("lit_first_char", 32'(first_char[0]), 32'h41);

    // Two-lookup chain 0x101 -> A B C.
    push_exp(8'h41, 1'b0); push_exp(8'h42, 1'b0); push_exp(8'h43, 1'b1);
    run(0, 13'h101, 6, 10);
    chk("chain_first_char", 32'(first_char[0]), 32'h41);

    // Stalled output; code_valid held so the next code waits for the drain.
    rdy_mode = 1;
    push_exp(8'h41, 1'b0); push_exp(8'h42, 1'b0); push_exp(8'h43, 1'b1);
    push_exp(8'h41, 1'b1);
    @(negedge clk);
    code_valid[0] = 1'b1;
    code_in[0]    = 13'h101;
    @(negedge clk);
    code_in[0] = 13'h041;
    k = 0;
    while (!code_ready[0] && k < 200) begin @(negedge clk); k++; end
    chk("stall_ready_bound", 32'(k < 200), 32'd1);
    chk("stall_no_early_accept", 32'(exp_q.size()), 32'd1);
    @(negedge clk);
    code_valid[0] = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || !code_ready[0]) && k < 200) begin @(negedge clk); k++; end
    chk("stall_drain", 32'(exp_q.size()), 32'd0);
    rdy_mode = 0;

    // Reset in LOOKUP.
    @(negedge clk);
    code_valid[0] = 1'b1;
    code_in[0]    = 13'h101;
    @(negedge clk);
    code_valid[0] = 1'b0;
    chk("in_lookup_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset(0, "rst_lookup");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-EMIT with output stalled.
    rdy_mode = 2;
    @(negedge clk);
    code_valid[0] = 1'b1;
    code_in[0]    = 13'h101;
    @(negedge clk);
    code_valid[0] = 1'b0;
    k = 0;
    while (!char_valid[0] && k < 100) begin @(negedge clk); k++; end
    chk("emit_top_root", 32'(char_out[0]), 32'h41);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset(0, "rst_emit");
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    push_exp(8'h41, 1'b0); push_exp(8'h42, 1'b0); push_exp(8'h43, 1'b1);
    run(0, 13'h101, 6, 10);

    // Overflow on a 4-deep stack with a 5-entry chain.
    sel = 1;
    @(negedge clk);
    code_valid[1] = 1'b1;
    code_in[1]    = 13'h204;
    @(negedge clk);
    code_valid[1] = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!code_ready[1] && k < 100) begin
      seen = seen | char_valid[1];
      @(negedge clk);
      k++;
    end
    chk("ovf_no_char_valid", 32'(seen), 32'd0);
    chk("ovf_flag", 32'(err_overflow[1]), 32'd1);
    chk("ovf_idle", 32'(busy[1]), 32'd0);
    push_exp(8'h5A, 1'b1);
    run(1, 13'h05A, 2, 4);
    chk("ovf_sticky", 32'(err_overflow[1]), 32'd1);
    chk("ovf_first_char", 32'(first_char[1]), 32'h5A);

    // RD_LAT=3 chain.
    sel = 2;
    push_exp(8'h41, 1'b0); push_exp(8'h42, 1'b0); push_exp(8'h43, 1'b1);
    run(2, 13'h101, 10, 14);
    chk("lat3_first_char", 32'(first_char[2]), 32'h41);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
